// File: rtl/cam_gray_pingpong_writer_pkg.sv
// Shared constants and types for the camera grayscale ping-pong frame writer.
package cam_pkg;

    // Luma weights, scaled by 256: Y = (77R + 150G + 29B) >> 8
    localparam logic [7:0] COEF_R = 8'd77;
    localparam logic [7:0] COEF_G = 8'd150;
    localparam logic [7:0] COEF_B = 8'd29;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        ARMED     = 2'd1,
        WRITE     = 2'd2,
        SKIP      = 2'd3
    } cam_state_e;

    typedef logic bank_t;

endpackage

// File: rtl/cam_gray_pingpong_writer_if.sv
// Capture write stream in, frame-buffer write port and consumer bank handshake out.
interface cam_gray_pingpong_writer_if #(
    parameter int ADDR_WIDTH = 17
);
    import cam_pkg::*;

    logic                  vsync;
    logic                  we;
    logic [ADDR_WIDTH-1:0] wAddr;
    logic [23:0]           wData;

    logic                  fb_we;
    logic [ADDR_WIDTH:0]   fb_addr;
    logic [7:0]            fb_data;

    // Consumer handshake: rd_valid stays high with rd_bank stable until a
    // one-cycle rd_ack pulse seen while rd_valid=1 releases that bank.
    logic                  rd_valid;
    bank_t                 rd_bank;
    logic                  rd_ack;

    logic                  frame_done;
    logic [15:0]           drop_cnt;

    modport master (
        output vsync, we, wAddr, wData, rd_ack,
        input  fb_we, fb_addr, fb_data, rd_valid, rd_bank, frame_done, drop_cnt
    );

    modport slave (
        input  vsync, we, wAddr, wData, rd_ack,
        output fb_we, fb_addr, fb_data, rd_valid, rd_bank, frame_done, drop_cnt
    );

endinterface

// File: rtl/cam_gray_pingpong_writer_rgb2luma.sv
// Two-stage RGB888 to 8-bit luma pipeline; strobe, address and vsync travel alongside.
module cam_rgb2luma
    import cam_pkg::*;
#(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [23:0]           rgb_i,
    input  logic                  vsync_i,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [7:0]            luma_o,
    output logic                  vsync_o
);

    logic [15:0]           pr_q, pg_q, pb_q;
    logic [15:0]           pr_d, pg_d, pb_d;
    logic                  we1_q, vs1_q;
    logic [ADDR_WIDTH-1:0] addr1_q;

    logic [7:0]            luma_q, luma_d;
    logic                  we2_q, vs2_q;
    logic [ADDR_WIDTH-1:0] addr2_q;

    assign pr_d = {8'd0, rgb_i[23:16]} * {8'd0, COEF_R};
    assign pg_d = {8'd0, rgb_i[15:8]}  * {8'd0, COEF_G};
    assign pb_d = {8'd0, rgb_i[7:0]}   * {8'd0, COEF_B};

    // The weights sum to 256, so the total peaks at 65280 and never carries out of 16 bits.
    assign luma_d = 8'((pr_q + pg_q + pb_q) >> 8);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pr_q    <= '0;
            pg_q    <= '0;
            pb_q    <= '0;
            we1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            addr1_q <= '0;
            luma_q  <= '0;
            we2_q   <= 1'b0;
            vs2_q   <= 1'b0;
            addr2_q <= '0;
        end else begin
            pr_q    <= pr_d;
            pg_q    <= pg_d;
            pb_q    <= pb_d;
            we1_q   <= we_i;
            vs1_q   <= vsync_i;
            addr1_q <= addr_i;
            luma_q  <= luma_d;
            we2_q   <= we1_q;
            vs2_q   <= vs1_q;
            addr2_q <= addr1_q;
        end
    end

    assign we_o    = we2_q;
    assign addr_o  = addr2_q;
    assign luma_o  = luma_q;
    assign vsync_o = vs2_q;

endmodule

// File: rtl/cam_gray_pingpong_writer.sv
// Writes luma frames into two ping-pong banks and hands full banks to the consumer.
module cam_gray_pingpong_writer
    import cam_pkg::*;
#(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                         pclk,
    input  logic                         reset,
    cam_gray_pingpong_writer_if.slave    bus,
    output cam_state_e                   dbg_state_o
);

    localparam int PIX_N = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W = $clog2(PIX_N + 2);
    localparam logic [CNT_W-1:0] PIX_FULL = CNT_W'(PIX_N);
    localparam logic [CNT_W-1:0] PIX_SAT  = CNT_W'(PIX_N + 1);

    logic                  we2, vs2;
    logic [ADDR_WIDTH-1:0] addr2;
    logic [7:0]            luma2;

    cam_rgb2luma #(.ADDR_WIDTH(ADDR_WIDTH)) u_rgb2luma (
        .clk_i   (pclk),
        .rst_ni  (reset),
        .we_i    (bus.we),
        .addr_i  (bus.wAddr),
        .rgb_i   (bus.wData),
        .vsync_i (bus.vsync),
        .we_o    (we2),
        .addr_o  (addr2),
        .luma_o  (luma2),
        .vsync_o (vs2)
    );

    cam_state_e       state_q, state_d;
    logic             vs_prev_q;
    logic [1:0]       full_q, full_d;
    bank_t            oldest_q, oldest_d;
    bank_t            last_q, last_d;
    bank_t            wr_bank_q, wr_bank_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [15:0]      drop_q, drop_d;
    logic             frame_done_q, frame_done_d;
    logic             drop_inc;
    logic             vs_rise, vs_fall, ack, fb_we;

    assign vs_rise = vs2 & ~vs_prev_q;
    assign vs_fall = ~vs2 & vs_prev_q;
    assign ack     = bus.rd_ack & (|full_q);
    assign fb_we   = (state_q == WRITE) & we2;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state_q      <= WAIT_SYNC;
            vs_prev_q    <= 1'b0;
            full_q       <= '0;
            oldest_q     <= 1'b0;
            last_q       <= 1'b1;  // so the first frame after reset lands in bank 0
            wr_bank_q    <= 1'b0;
            pix_cnt_q    <= '0;
            drop_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_prev_q    <= vs2;
            full_q       <= full_d;
            oldest_q     <= oldest_d;
            last_q       <= last_d;
            wr_bank_q    <= wr_bank_d;
            pix_cnt_q    <= pix_cnt_d;
            drop_q       <= drop_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        full_d       = full_q;
        oldest_d     = oldest_q;
        last_d       = last_q;
        wr_bank_d    = wr_bank_q;
        pix_cnt_d    = pix_cnt_q;
        frame_done_d = 1'b0;
        drop_inc     = 1'b0;

        if (ack) full_d[oldest_q] = 1'b0;

        case (state_q)
            WAIT_SYNC: if (vs_rise) state_d = ARMED;
            ARMED: begin
                if (vs_fall) begin
                    pix_cnt_d = '0;
                    if (!full_q[~last_q]) begin
                        wr_bank_d = ~last_q;
                        state_d   = WRITE;
                    end else if (!full_q[last_q]) begin
                        wr_bank_d = last_q;
                        state_d   = WRITE;
                    end else begin
                        state_d  = SKIP;
                        drop_inc = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (fb_we && pix_cnt_q != PIX_SAT) pix_cnt_d = pix_cnt_q + 1'b1;
                if (vs_rise) begin
                    state_d = ARMED;
                    if (pix_cnt_q == PIX_FULL) begin
                        full_d[wr_bank_q] = 1'b1;
                        frame_done_d      = 1'b1;
                        last_d            = wr_bank_q;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            SKIP: if (vs_rise) state_d = ARMED;
            default: state_d = WAIT_SYNC;
        endcase

        // With two full banks the older one keeps the read pointer.
        case (full_d)
            2'b01:   oldest_d = 1'b0;
            2'b10:   oldest_d = 1'b1;
            default: oldest_d = oldest_q;
        endcase

        drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    assign bus.fb_we      = fb_we;
    assign bus.fb_addr    = {wr_bank_q, addr2};
    assign bus.fb_data    = luma2;
    assign bus.rd_valid   = |full_q;
    assign bus.rd_bank    = oldest_q;
    assign bus.frame_done = frame_done_q;
    assign bus.drop_cnt   = drop_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_cam_gray_pingpong_writer.sv
// Directed bench for the grayscale ping-pong frame writer on a reduced 16x8 frame.
module tb_cam_gray_pingpong_writer;
    import cam_pkg::*;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int N  = W * H;
    localparam int AW = 7;

    logic pclk  = 1'b0;
    logic reset = 1'b0;
    always #5 pclk = ~pclk;

    cam_gray_pingpong_writer_if #(.ADDR_WIDTH(AW)) bus();
    cam_state_e dbg_state;

    cam_gray_pingpong_writer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW)) dut (
        .pclk        (pclk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;
    logic [AW+8:0] obs_q[$];
    logic [AW+8:0] exp_q[$];

    always @(negedge pclk) begin
        if (bus.fb_we === 1'b1) obs_q.push_back({bus.fb_addr, bus.fb_data});
        if (bus.frame_done === 1'b1) fd_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] pix_rgb(input int i, input int seed);
        logic [7:0] r, g, b;
        if (seed < 0) return 24'hFFFFFF;
        r = 8'(i * 7 + seed);
        g = 8'(i * 13 + seed * 5);
        b = 8'(i * 29 + 3);
        return {r, g, b};
    endfunction

    function automatic logic [7:0] luma_ref(input logic [23:0] c);
        int y;
        y = (77 * int'(c[23:16]) + 150 * int'(c[15:8]) + 29 * int'(c[7:0])) >> 8;
        return 8'(y);
    endfunction

    task automatic do_reset();
        bus.vsync  = 1'b0;
        bus.we     = 1'b0;
        bus.wAddr  = '0;
        bus.wData  = '0;
        bus.rd_ack = 1'b0;
        reset      = 1'b0;
        repeat (3) @(posedge pclk);
        #1 reset = 1'b1;
        obs_q.delete();
        exp_q.delete();
        fd_cnt = 0;
    endtask

    task automatic sync_start();
        @(posedge pclk);
        #1 bus.vsync = 1'b1;
        repeat (4) @(posedge pclk);
        #1;
    endtask

    task automatic run_frame(input int npix, input int seed);
        @(posedge pclk);
        #1 bus.vsync = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        for (int i = 0; i < npix; i++) begin
            bus.we    = 1'b1;
            bus.wAddr = AW'(i);
            bus.wData = pix_rgb(i, seed);
            @(posedge pclk);
            #1;
        end
        bus.we = 1'b0;
        repeat (3) @(posedge pclk);
        #1 bus.vsync = 1'b1;
        repeat (6) @(posedge pclk);
        #1;
    endtask

    task automatic ack_pulse();
        @(posedge pclk);
        #1 bus.rd_ack = 1'b1;
        @(posedge pclk);
        #1 bus.rd_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge pclk);
        total++; if (bus.fb_we !== 1'b0) begin bad++; $display("FAIL reset_fb_we: got %0h want 0", bus.fb_we); end
        total++; if (bus.fb_addr !== '0) begin bad++; $display("FAIL reset_fb_addr: got %0h want 0", bus.fb_addr); end
        total++; if (bus.fb_data !== 8'h00) begin bad++; $display("FAIL reset_fb_data: got %0h want 0", bus.fb_data); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %0h want 0", bus.rd_valid); end
        total++; if (bus.rd_bank !== 1'b0) begin bad++; $display("FAIL reset_rd_bank: got %0h want 0", bus.rd_bank); end
        total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %0h want 0", bus.frame_done); end
        total++; if (bus.drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop_cnt: got %0d want 0", bus.drop_cnt); end
        total++; if (dbg_state !== WAIT_SYNC) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, WAIT_SYNC); end
    endtask

    task automatic test_single_pixel();
        logic [23:0] rgb_t[4];
        logic [7:0]  y_t[4];
        logic [AW-1:0] a;
        rgb_t = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h000000};
        y_t   = '{8'd76, 8'd149, 8'd28, 8'd0};
        do_reset();
        sync_start();
        bus.vsync = 1'b0;
        repeat (4) @(posedge pclk);
        @(negedge pclk);
        total++; if (dbg_state !== WRITE) begin bad++; $display("FAIL px_state: got %0d want %0d", dbg_state, WRITE); end
        @(posedge pclk);
        #1;
        for (int k = 0; k < 4; k++) begin
            a = AW'(k + 5);
            bus.we = 1'b1; bus.wAddr = a; bus.wData = rgb_t[k];
            @(posedge pclk);
            #1 bus.we = 1'b0;
            @(negedge pclk);
            total++; if (bus.fb_we !== 1'b0) begin bad++; $display("FAIL px%0d_early: fb_we got %0h want 0", k, bus.fb_we); end
            @(posedge pclk);
            @(negedge pclk);
            total++; if (bus.fb_we !== 1'b1) begin bad++; $display("FAIL px%0d_we: got %0h want 1", k, bus.fb_we); end
            total++; if (bus.fb_data !== y_t[k]) begin bad++; $display("FAIL px%0d_data: got %0d want %0d", k, bus.fb_data, y_t[k]); end
            total++; if (bus.fb_addr !== {1'b0, a}) begin bad++; $display("FAIL px%0d_addr: got %0h want %0h", k, bus.fb_addr, {1'b0, a}); end
            @(posedge pclk);
            @(negedge pclk);
            total++; if (bus.fb_we !== 1'b0) begin bad++; $display("FAIL px%0d_late: fb_we got %0h want 0", k, bus.fb_we); end
            @(posedge pclk);
            #1;
        end
        bus.vsync = 1'b1;
        repeat (6) @(posedge pclk);
        @(negedge pclk);
        total++; if (fd_cnt !== 0) begin bad++; $display("FAIL px_frame_done: got %0d want 0", fd_cnt); end
        total++; if (bus.drop_cnt !== 16'd1) begin bad++; $display("FAIL px_drop: got %0d want 1", bus.drop_cnt); end
    endtask

    task automatic test_full_frame();
        do_reset();
        sync_start();
        run_frame(N, -1);
        for (int i = 0; i < N; i++) exp_q.push_back({1'b0, AW'(i), 8'hFF});
        @(negedge pclk);
        total++; if (obs_q.size() !== N) begin bad++; $display("FAIL full_count: got %0d want %0d", obs_q.size(), N); end
        for (int i = 0; i < N && i < obs_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_pix%0d: got %0h want %0h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (fd_cnt !== 1) begin bad++; $display("FAIL full_frame_done: got %0d want 1", fd_cnt); end
        total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL full_rd_valid: got %0h want 1", bus.rd_valid); end
        total++; if (bus.rd_bank !== 1'b0) begin bad++; $display("FAIL full_rd_bank: got %0h want 0", bus.rd_bank); end
        total++; if (bus.drop_cnt !== 16'd0) begin bad++; $display("FAIL full_drop: got %0d want 0", bus.drop_cnt); end
    endtask

    task automatic test_three_frames();
        do_reset();
        sync_start();
        run_frame(N, 3);
        run_frame(N, 11);
        for (int i = 0; i < N; i++) exp_q.push_back({1'b0, AW'(i), luma_ref(pix_rgb(i, 3))});
        for (int i = 0; i < N; i++) exp_q.push_back({1'b1, AW'(i), luma_ref(pix_rgb(i, 11))});
        run_frame(N, 20);
        @(negedge pclk);
        total++; if (obs_q.size() !== 2 * N) begin bad++; $display("FAIL three_count: got %0d want %0d", obs_q.size(), 2 * N); end
        for (int i = 0; i < 2 * N && i < obs_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL three_pix%0d: got %0h want %0h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (fd_cnt !== 2) begin bad++; $display("FAIL three_frame_done: got %0d want 2", fd_cnt); end
        total++; if (bus.drop_cnt !== 16'd1) begin bad++; $display("FAIL three_drop: got %0d want 1", bus.drop_cnt); end
        total++; if (bus.rd_bank !== 1'b0) begin bad++; $display("FAIL three_rd_bank0: got %0h want 0", bus.rd_bank); end
        ack_pulse();
        @(negedge pclk);
        total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL three_valid_after_ack: got %0h want 1", bus.rd_valid); end
        total++; if (bus.rd_bank !== 1'b1) begin bad++; $display("FAIL three_rd_bank1: got %0h want 1", bus.rd_bank); end
        ack_pulse();
        @(negedge pclk);
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL three_valid_empty: got %0h want 0", bus.rd_valid); end
    endtask

    task automatic test_short_frame();
        do_reset();
        sync_start();
        run_frame(10, 5);
        @(negedge pclk);
        total++; if (fd_cnt !== 0) begin bad++; $display("FAIL short_frame_done: got %0d want 0", fd_cnt); end
        total++; if (bus.drop_cnt !== 16'd1) begin bad++; $display("FAIL short_drop: got %0d want 1", bus.drop_cnt); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL short_rd_valid: got %0h want 0", bus.rd_valid); end
        run_frame(N + 3, 6);
        @(negedge pclk);
        total++; if (fd_cnt !== 0) begin bad++; $display("FAIL long_frame_done: got %0d want 0", fd_cnt); end
        total++; if (bus.drop_cnt !== 16'd2) begin bad++; $display("FAIL long_drop: got %0d want 2", bus.drop_cnt); end
        @(posedge pclk);
        #1 obs_q.delete();
        run_frame(N, 7);
        @(negedge pclk);
        total++; if (fd_cnt !== 1) begin bad++; $display("FAIL after_short_frame_done: got %0d want 1", fd_cnt); end
        total++; if (bus.rd_bank !== 1'b0) begin bad++; $display("FAIL after_short_rd_bank: got %0h want 0", bus.rd_bank); end
        total++; if (obs_q.size() !== N) begin bad++; $display("FAIL after_short_count: got %0d want %0d", obs_q.size(), N); end
        if (obs_q.size() == N) begin
            total++;
            if (obs_q[N-1] !== {1'b0, AW'(N - 1), luma_ref(pix_rgb(N - 1, 7))}) begin
                bad++; $display("FAIL after_short_last: got %0h want %0h", obs_q[N-1], {1'b0, AW'(N - 1), luma_ref(pix_rgb(N - 1, 7))});
            end
        end
    endtask

    task automatic test_ack_collision();
        do_reset();
        sync_start();
        run_frame(N, 1);
        @(posedge pclk);
        #1 bus.vsync = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        for (int i = 0; i < N; i++) begin
            bus.we = 1'b1; bus.wAddr = AW'(i); bus.wData = pix_rgb(i, 2);
            @(posedge pclk);
            #1;
        end
        bus.we = 1'b0;
        repeat (3) @(posedge pclk);
        #1 bus.vsync = 1'b1;
        @(posedge pclk);
        @(posedge pclk);
        #1 bus.rd_ack = 1'b1;
        @(negedge pclk);
        total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL coll_done_early: got %0h want 0", bus.frame_done); end
        total++; if (bus.rd_bank !== 1'b0) begin bad++; $display("FAIL coll_bank_before: got %0h want 0", bus.rd_bank); end
        @(posedge pclk);
        #1 bus.rd_ack = 1'b0;
        @(negedge pclk);
        total++; if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL coll_frame_done: got %0h want 1", bus.frame_done); end
        total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL coll_rd_valid: got %0h want 1", bus.rd_valid); end
        total++; if (bus.rd_bank !== 1'b1) begin bad++; $display("FAIL coll_rd_bank: got %0h want 1", bus.rd_bank); end
        ack_pulse();
        @(negedge pclk);
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL coll_only_bank1: rd_valid got %0h want 0", bus.rd_valid); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        sync_start();
        run_frame(10, 4);
        run_frame(N, 8);
        @(posedge pclk);
        #1 bus.vsync = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        for (int i = 0; i < 20; i++) begin
            bus.we = 1'b1; bus.wAddr = AW'(i + 40); bus.wData = pix_rgb(i, 9);
            @(posedge pclk);
            #1;
        end
        total++; if (bus.fb_we !== 1'b1) begin bad++; $display("FAIL mid_pre_we: got %0h want 1", bus.fb_we); end
        #2 reset = 1'b0;
        #1;
        total++; if (bus.fb_we !== 1'b0) begin bad++; $display("FAIL mid_async_we: got %0h want 0", bus.fb_we); end
        total++; if (bus.fb_addr !== '0) begin bad++; $display("FAIL mid_async_addr: got %0h want 0", bus.fb_addr); end
        total++; if (bus.fb_data !== 8'h00) begin bad++; $display("FAIL mid_async_data: got %0h want 0", bus.fb_data); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid: got %0h want 0", bus.rd_valid); end
        total++; if (bus.drop_cnt !== 16'd0) begin bad++; $display("FAIL mid_async_drop: got %0d want 0", bus.drop_cnt); end
        total++; if (dbg_state !== WAIT_SYNC) begin bad++; $display("FAIL mid_async_state: got %0d want %0d", dbg_state, WAIT_SYNC); end
        repeat (3) @(posedge pclk);
        #1 reset = 1'b1;
        obs_q.delete();
        fd_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            bus.we = 1'b1; bus.wAddr = AW'(i + 70); bus.wData = pix_rgb(i, 12);
            @(posedge pclk);
            #1;
        end
        bus.we = 1'b0;
        repeat (3) @(posedge pclk);
        #1 bus.vsync = 1'b1;
        repeat (6) @(posedge pclk);
        @(negedge pclk);
        total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL mid_no_write: got %0d writes want 0", obs_q.size()); end
        total++; if (fd_cnt !== 0) begin bad++; $display("FAIL mid_no_done: got %0d want 0", fd_cnt); end
        total++; if (bus.drop_cnt !== 16'd0) begin bad++; $display("FAIL mid_drop: got %0d want 0", bus.drop_cnt); end
        run_frame(N, 9);
        @(negedge pclk);
        total++; if (fd_cnt !== 1) begin bad++; $display("FAIL mid_next_done: got %0d want 1", fd_cnt); end
        total++; if (obs_q.size() !== N) begin bad++; $display("FAIL mid_next_count: got %0d want %0d", obs_q.size(), N); end
        total++; if (bus.rd_bank !== 1'b0) begin bad++; $display("FAIL mid_next_bank: got %0h want 0", bus.rd_bank); end
        if (obs_q.size() > 0) begin
            total++;
            if (obs_q[0] !== {1'b0, AW'(0), luma_ref(pix_rgb(0, 9))}) begin
                bad++; $display("FAIL mid_next_first: got %0h want %0h", obs_q[0], {1'b0, AW'(0), luma_ref(pix_rgb(0, 9))});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_full_frame();
        test_three_frames();
        test_short_frame();
        test_ack_collision();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
